// File: rtl/game_pkg.sv
// Shared game-flow types for the runner pipeline (sequencer, spawn and collision blocks).
package game_pkg;

  localparam int unsigned SCORE_W = 16;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_COUNT,
    ST_LOGO,
    ST_ENTER,
    ST_PLAY,
    ST_OVER
  } game_state_t;

endpackage

// File: rtl/game_sequencer_if.sv
// Control/status bundle between the game sequencer and the display pipeline.
interface game_sequencer_if #(
  parameter int unsigned W     = 12,
  parameter int unsigned LANES = 3
);
  import game_pkg::*;

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic                frame_tick;
  logic                btn_left;
  logic                btn_right;
  logic                btn_restart;
  logic                hit;
  game_state_t         state_o;
  logic                playing;
  logic [W-1:0]        logo_voffset;
  logic [W-1:0]        player_voffset;
  logic signed [W-1:0] player_hoffset;
  logic [LW-1:0]       lane;
  logic [SCORE_W-1:0]  frame_count;

  modport master (
    output frame_tick, btn_left, btn_right, btn_restart, hit,
    input  state_o, playing, logo_voffset, player_voffset, player_hoffset, lane, frame_count
  );

  modport slave (
    input  frame_tick, btn_left, btn_right, btn_restart, hit,
    output state_o, playing, logo_voffset, player_voffset, player_hoffset, lane, frame_count
  );

endinterface

// File: rtl/btn_edge.sv
// Two-flop synchroniser for a raw button followed by a 1-cycle rising-edge pulse.
module btn_edge (
  input  logic CLK100MHZ,
  input  logic CPU_RESETN,
  input  logic btn,
  output logic pulse
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/game_sequencer.sv
// Frame-paced game-flow controller: countdown, logo fade-out, player entry, play, game-over,
// plus lane selection and layer offsets. All state advances only on frame_tick.
module game_sequencer
  import game_pkg::*;
#(
  parameter int unsigned W            = 12,
  parameter int unsigned LANES        = 3,
  parameter int unsigned LANE_STEP    = 100,
  parameter int unsigned COUNTDOWN    = 5,
  parameter int unsigned LOGO_STEP    = 30,
  parameter int unsigned LOGO_END     = 640,
  parameter int unsigned PLAYER_START = 180,
  parameter int unsigned PLAYER_END   = 50,
  parameter int unsigned PLAYER_STEP  = 20
) (
  input logic             CLK100MHZ,
  input logic             CPU_RESETN,
  game_sequencer_if.slave bus
);

  localparam int unsigned LW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned CW = $clog2(COUNTDOWN + 1) > 0 ? $clog2(COUNTDOWN + 1) : 1;

  localparam logic [CW-1:0] CountInit   = CW'(COUNTDOWN);
  localparam logic [W-1:0]  LogoEnd     = W'(LOGO_END);
  localparam logic [W:0]    LogoStep    = (W + 1)'(LOGO_STEP);
  localparam logic [W-1:0]  PlayerStart = W'(PLAYER_START);
  localparam logic [W-1:0]  PlayerEnd   = W'(PLAYER_END);
  localparam logic [W-1:0]  PlayerStep  = W'(PLAYER_STEP);
  localparam logic [LW-1:0] Center      = LW'((LANES - 1) / 2);
  localparam logic [LW-1:0] LaneMax     = LW'(LANES - 1);

  if (LANES < 2 || LANES * LANE_STEP >= (1 << (W - 1))) begin : g_param_check
    $error("game_sequencer: LANES must be >= 2 and LANES*LANE_STEP must fit in W-1 bits");
  end

  logic left_edge, right_edge, restart_edge;

  btn_edge u_btn_left (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .btn       (bus.btn_left),
    .pulse     (left_edge)
  );

  btn_edge u_btn_right (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .btn       (bus.btn_right),
    .pulse     (right_edge)
  );

  btn_edge u_btn_restart (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .btn       (bus.btn_restart),
    .pulse     (restart_edge)
  );

  game_state_t        state_q, state_d;
  logic [CW-1:0]      countdown_q, countdown_d;
  logic [W-1:0]       logo_q, logo_d;
  logic [W-1:0]       player_q, player_d;
  logic [LW-1:0]      lane_q, lane_d;
  logic [SCORE_W-1:0] frame_count_q, frame_count_d;
  logic left_pend_q, left_pend_d, right_pend_q, right_pend_d;
  logic hit_pend_q, hit_pend_d, restart_pend_q, restart_pend_d;

  logic       tick;
  logic [W:0] logo_sum;
  logic       player_near_end;

  assign tick            = bus.frame_tick;
  assign logo_sum        = {1'b0, logo_q} + LogoStep;
  assign player_near_end = ({1'b0, player_q} <= ({1'b0, PlayerEnd} + {1'b0, PlayerStep}));

  always_comb begin
    state_d       = state_q;
    countdown_d   = countdown_q;
    logo_d        = logo_q;
    player_d      = player_q;
    lane_d        = lane_q;
    frame_count_d = frame_count_q;
    // An edge arriving on the tick cycle survives into the next frame.
    left_pend_d    = tick ? left_edge    : (left_pend_q | left_edge);
    right_pend_d   = tick ? right_edge   : (right_pend_q | right_edge);
    restart_pend_d = tick ? restart_edge : (restart_pend_q | restart_edge);
    hit_pend_d     = (bus.hit && state_q == ST_PLAY) || (hit_pend_q && !tick);

    if (tick) begin
      unique case (state_q)
        ST_RESET: begin
          state_d     = ST_COUNT;
          countdown_d = CountInit;
          logo_d      = '0;
          player_d    = PlayerStart;
          lane_d      = Center;
        end
        ST_COUNT: begin
          if (countdown_q != '0) countdown_d = countdown_q - CW'(1);
          else                   state_d     = ST_LOGO;
        end
        ST_LOGO: begin
          if (logo_q < LogoEnd) logo_d  = (logo_sum >= {1'b0, LogoEnd}) ? LogoEnd : logo_sum[W-1:0];
          else                  state_d = ST_ENTER;
        end
        ST_ENTER: begin
          if (player_q > PlayerEnd) player_d = player_near_end ? PlayerEnd : player_q - PlayerStep;
          else                      state_d  = ST_PLAY;
        end
        ST_PLAY: begin
          if (frame_count_q != '1) frame_count_d = frame_count_q + SCORE_W'(1);
          if (left_pend_q && !right_pend_q && lane_q != '0)       lane_d = lane_q - LW'(1);
          else if (right_pend_q && !left_pend_q && lane_q != LaneMax) lane_d = lane_q + LW'(1);
          if (hit_pend_q) state_d = ST_OVER;
        end
        ST_OVER: begin
          // Restart lands in the same condition as a hardware reset.
          if (restart_pend_q) begin
            state_d       = ST_RESET;
            frame_count_d = '0;
            countdown_d   = CountInit;
            logo_d        = '0;
            player_d      = PlayerStart;
            lane_d        = Center;
          end
        end
        default: state_d = ST_RESET;
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q        <= ST_RESET;
      countdown_q    <= CountInit;
      logo_q         <= '0;
      player_q       <= PlayerStart;
      lane_q         <= Center;
      frame_count_q  <= '0;
      left_pend_q    <= 1'b0;
      right_pend_q   <= 1'b0;
      hit_pend_q     <= 1'b0;
      restart_pend_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      countdown_q    <= countdown_d;
      logo_q         <= logo_d;
      player_q       <= player_d;
      lane_q         <= lane_d;
      frame_count_q  <= frame_count_d;
      left_pend_q    <= left_pend_d;
      right_pend_q   <= right_pend_d;
      hit_pend_q     <= hit_pend_d;
      restart_pend_q <= restart_pend_d;
    end
  end

  assign bus.state_o        = state_q;
  assign bus.playing        = (state_q == ST_PLAY);
  assign bus.logo_voffset   = logo_q;
  assign bus.player_voffset = player_q;
  assign bus.lane           = lane_q;
  assign bus.frame_count    = frame_count_q;
  assign bus.player_hoffset = W'((int'(lane_q) - int'(Center)) * int'(LANE_STEP));

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: each tick pushes its expected post-tick outputs,
// a monitor pops and compares them on the half-cycle after every ticked clock edge.
module tb_game_sequencer;
  import game_pkg::*;

  logic CLK100MHZ = 1'b0;
  logic CPU_RESETN = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  game_sequencer_if bus ();

  game_sequencer dut (
    .CLK100MHZ (CLK100MHZ),
    .CPU_RESETN(CPU_RESETN),
    .bus       (bus)
  );

  // A field of -1 is not checked for that tick.
  typedef struct {
    string       name;
    game_state_t st;
    int          lane;
    int          logo;
    int          player;
    int          fc;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad   = 0;

  function automatic exp_t mk(input string n, input game_state_t st, input int lane,
                              input int logo, input int player, input int fc);
    exp_t e;
    e.name = n; e.st = st; e.lane = lane; e.logo = logo; e.player = player; e.fc = fc;
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_out(input exp_t e);
    check({e.name, ".state"}, int'(bus.state_o), int'(e.st));
    check({e.name, ".playing"}, int'(bus.playing), (e.st == ST_PLAY) ? 1 : 0);
    if (e.lane >= 0) begin
      check({e.name, ".lane"}, int'(bus.lane), e.lane);
      check({e.name, ".hoffset"}, int'($signed(bus.player_hoffset)), (e.lane - 1) * 100);
    end
    if (e.logo >= 0)   check({e.name, ".logo"}, int'(bus.logo_voffset), e.logo);
    if (e.player >= 0) check({e.name, ".player"}, int'(bus.player_voffset), e.player);
    if (e.fc >= 0)     check({e.name, ".frame_count"}, int'(bus.frame_count), e.fc);
  endtask

  // Monitor
  initial begin
    forever begin
      @(posedge CLK100MHZ);
      if (bus.frame_tick && CPU_RESETN) begin
        @(negedge CLK100MHZ);
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underflow: got tick with no expectation queued, required one");
        end else begin
          compare_out(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required $finish before 2 ms");
    $fatal(1, "watchdog");
  end

  task automatic do_tick(input exp_t e);
    sb_q.push_back(e);
    @(negedge CLK100MHZ) bus.frame_tick = 1'b1;
    @(negedge CLK100MHZ) bus.frame_tick = 1'b0;
    repeat (8) @(negedge CLK100MHZ);
  endtask

  // 0 = left, 1 = right, 2 = restart
  task automatic press(input int which);
    @(negedge CLK100MHZ);
    if (which == 0) bus.btn_left = 1'b1;
    else if (which == 1) bus.btn_right = 1'b1;
    else bus.btn_restart = 1'b1;
    repeat (4) @(negedge CLK100MHZ);
    bus.btn_left = 1'b0; bus.btn_right = 1'b0; bus.btn_restart = 1'b0;
    repeat (4) @(negedge CLK100MHZ);
  endtask

  task automatic check_reset_state(input string n);
    check({n, ".state"}, int'(bus.state_o), int'(ST_RESET));
    check({n, ".logo"}, int'(bus.logo_voffset), 0);
    check({n, ".player"}, int'(bus.player_voffset), 180);
    check({n, ".lane"}, int'(bus.lane), 1);
    check({n, ".hoffset"}, int'($signed(bus.player_hoffset)), 0);
    check({n, ".frame_count"}, int'(bus.frame_count), 0);
  endtask

  initial begin
    bus.frame_tick = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    bus.btn_restart = 1'b0; bus.hit = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    CPU_RESETN = 1'b1;
    #1 check_reset_state("por");

    // Part-way into the logo fade, then reset asynchronously.
    do_tick(mk("a_t1", ST_COUNT, 1, 0, 180, 0));
    for (int k = 2; k <= 6; k++) do_tick(mk("a_count", ST_COUNT, 1, 0, 180, 0));
    do_tick(mk("a_t7", ST_LOGO, 1, 0, 180, 0));
    for (int k = 1; k <= 5; k++) do_tick(mk("a_logo", ST_LOGO, 1, 30 * k, 180, 0));
    @(negedge CLK100MHZ) CPU_RESETN = 1'b0;
    #1 check_reset_state("midlogo_rst");
    @(negedge CLK100MHZ) CPU_RESETN = 1'b1;

    // Full default flow: 38 ticks to ST_PLAY.
    do_tick(mk("t1", ST_COUNT, 1, 0, 180, 0));
    for (int k = 2; k <= 6; k++) do_tick(mk("count", ST_COUNT, 1, 0, 180, 0));
    do_tick(mk("t7", ST_LOGO, 1, 0, 180, 0));
    for (int k = 1; k <= 22; k++)
      do_tick(mk("logo", ST_LOGO, 1, (30 * k > 640) ? 640 : 30 * k, 180, 0));
    do_tick(mk("t30", ST_ENTER, 1, 640, 180, 0));
    for (int k = 1; k <= 7; k++)
      do_tick(mk("enter", ST_ENTER, 1, 640, (180 - 20 * k < 50) ? 50 : 180 - 20 * k, 0));
    do_tick(mk("t38", ST_PLAY, 1, 640, 50, 0));

    // Lane moves.
    press(0); press(0);
    do_tick(mk("left_x2", ST_PLAY, 0, 640, 50, 1));
    press(0);
    do_tick(mk("left_clamp", ST_PLAY, 0, 640, 50, 2));
    press(1);
    do_tick(mk("right1", ST_PLAY, 1, 640, 50, 3));
    press(1);
    do_tick(mk("right2", ST_PLAY, 2, 640, 50, 4));
    press(0); press(1);
    do_tick(mk("both", ST_PLAY, 2, 640, 50, 5));

    // Left edge pulse coincides with the tick edge: retained for the next frame.
    @(negedge CLK100MHZ) bus.btn_left = 1'b1;
    @(negedge CLK100MHZ);
    @(negedge CLK100MHZ) begin
      sb_q.push_back(mk("edge_on_tick", ST_PLAY, 2, 640, 50, 6));
      bus.frame_tick = 1'b1;
    end
    @(negedge CLK100MHZ) bus.frame_tick = 1'b0;
    repeat (3) @(negedge CLK100MHZ);
    bus.btn_left = 1'b0;
    repeat (6) @(negedge CLK100MHZ);
    do_tick(mk("edge_applied", ST_PLAY, 1, 640, 50, 7));
    for (int k = 8; k <= 10; k++) do_tick(mk("play", ST_PLAY, 1, 640, 50, k));

    // Hit ends the game; score frozen.
    @(negedge CLK100MHZ) bus.hit = 1'b1;
    @(negedge CLK100MHZ) bus.hit = 1'b0;
    do_tick(mk("hit", ST_OVER, 1, 640, 50, 11));
    press(0);
    do_tick(mk("over_frozen", ST_OVER, 1, 640, 50, 11));
    press(2);
    do_tick(mk("restart", ST_RESET, 1, 0, 180, 0));

    // Second run: a left edge in the ST_ENTER frame must not move the lane in ST_PLAY.
    for (int i = 1; i <= 37; i++)
      do_tick(mk("rerun", (i <= 6) ? ST_COUNT : (i <= 29) ? ST_LOGO : ST_ENTER, -1, -1, -1, 0));
    press(0);
    do_tick(mk("rerun_t38", ST_PLAY, 1, 640, 50, 0));
    do_tick(mk("no_stale_move", ST_PLAY, 1, 640, 50, 1));

    repeat (5) @(negedge CLK100MHZ);
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
